// File: rtl/irc_pkg.sv
// Shared types for the IR/button command scheduler: opcodes, FSM states,
// command records and the IR/button to command mapping helpers.
package irc_pkg;

    typedef enum logic [3:0] {
        OP_NOP        = 4'd0,
        OP_CAPTURE    = 4'd1,
        OP_MODE_NEXT  = 4'd2,
        OP_MODE_PREV  = 4'd3,
        OP_FILTER     = 4'd4,
        OP_MODE_RESET = 4'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [7:0] arg;
    } cmd_t;

    typedef struct packed {
        logic vld;
        cmd_t cmd;
    } ev_t;

    localparam cmd_t CMD_NOP = '{op: OP_NOP, arg: 8'h00};

    localparam logic [7:0] IR_CAPTURE    = 8'h12;
    localparam logic [7:0] IR_MODE_NEXT  = 8'h1A;
    localparam logic [7:0] IR_MODE_PREV  = 8'h1E;
    localparam logic [7:0] IR_FILTER_MAX = 8'h09;

    localparam logic SRC_IR  = 1'b0;
    localparam logic SRC_BTN = 1'b1;

    function automatic ev_t ir_map(input logic [7:0] code);
        ev_t ev;
        ev.vld = 1'b1;
        ev.cmd = CMD_NOP;
        case (code)
            IR_CAPTURE:   ev.cmd.op = OP_CAPTURE;
            IR_MODE_NEXT: ev.cmd.op = OP_MODE_NEXT;
            IR_MODE_PREV: ev.cmd.op = OP_MODE_PREV;
            default: begin
                if (code <= IR_FILTER_MAX) begin
                    ev.cmd.op  = OP_FILTER;
                    ev.cmd.arg = code;
                end else begin
                    ev.vld = 1'b0;
                end
            end
        endcase
        return ev;
    endfunction

    // Lowest button index wins when several edges land together.
    function automatic ev_t btn_map(input logic [3:0] fall);
        ev_t ev;
        ev.vld = 1'b1;
        ev.cmd = CMD_NOP;
        if (fall[0]) begin
            ev.cmd.op = OP_CAPTURE;
        end else if (fall[1]) begin
            ev.cmd.op = OP_MODE_NEXT;
        end else if (fall[2]) begin
            ev.cmd.op = OP_MODE_PREV;
        end else if (fall[3]) begin
            ev.cmd.op = OP_MODE_RESET;
        end else begin
            ev.vld = 1'b0;
        end
        return ev;
    endfunction

endpackage

// File: rtl/irc_cmd_fifo.sv
// Synchronous command FIFO; a push on a full FIFO is accepted when a pop
// happens in the same cycle.
module irc_cmd_fifo
    import irc_pkg::*;
#(
    parameter int unsigned DEPTH = 32'd4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 32'd1);

    cmd_t          mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (cnt_r == CW'(DEPTH));
    assign empty     = (cnt_r == {CW{1'b0}});
    assign rdata     = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage and pointer/occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= CMD_NOP;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(32'd1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(32'd1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CW'(32'd1);
                2'b01:   cnt_r <= cnt_r - CW'(32'd1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/ir_cmd_sched.sv
// IR/button command scheduler: map, holdoff, arbitrate, queue and issue camera commands.
// Optional EXEC timeout is built only when IRC_EXEC_TIMEOUT_EN is defined.
module ir_cmd_sched
    import irc_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYC = 32'd10_000_000,
    parameter int unsigned FIFO_DEPTH  = 32'd4,
    parameter int unsigned MODE_COUNT  = 32'd5
`ifdef IRC_EXEC_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 32'd50_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir_code,
    input  logic       ir_strobe,
    input  logic [3:0] btn_n,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [3:0] cmd_op,
    output logic [7:0] cmd_arg,
    input  logic       cmd_done,
    output logic [2:0] mode,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam int unsigned HW        = $clog2(HOLDOFF_CYC + 32'd1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF_CYC);
    localparam logic [2:0] MODE_LAST  = 3'(MODE_COUNT - 32'd1);

    logic [3:0]    btn_meta_r, btn_sync_r, btn_prev_r;
    logic [3:0]    btn_fall_s;
    logic [HW-1:0] ir_hold_r, btn_hold_r;
    logic [7:0]    ir_last_r;
    ev_t           ir_ev_s, btn_ev_s;
    logic          ir_evt_s, btn_evt_s;
    cmd_t          ir_pend_r, btn_pend_r;
    logic          ir_pend_vld_r, btn_pend_vld_r;
    logic          rr_r;
    logic          gnt_ir_s, gnt_btn_s, push_s;
    logic          ir_drop_s, btn_drop_s;
    cmd_t          push_cmd_s, fifo_head_s;
    logic          fifo_full_s, fifo_empty_s;
    state_e        state_r, state_nxt;
    logic          pop_s, hs_s, timeout_s;
    logic          cmd_valid_r, busy_r, is_mode_op_s;
    op_e           cmd_op_r;
    logic [7:0]    cmd_arg_r, issue_arg_s, drop_cnt_r;
    logic [2:0]    mode_r, mode_calc_s;
    logic [1:0]    drop_inc_s;
    logic [8:0]    drop_sum_s;

    assign btn_fall_s = btn_prev_r & ~btn_sync_r;
    assign cmd_valid  = cmd_valid_r;
    assign cmd_op     = cmd_op_r;
    assign cmd_arg    = cmd_arg_r;
    assign mode       = mode_r;
    assign busy       = busy_r;
    assign drop_cnt   = drop_cnt_r;

    // Button synchroniser and edge history; released (high) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_r <= 4'hF;
            btn_sync_r <= 4'hF;
            btn_prev_r <= 4'hF;
        end else begin
            btn_meta_r <= btn_n;
            btn_sync_r <= btn_meta_r;
            btn_prev_r <= btn_sync_r;
        end
    end

    // Source event qualification against the holdoff windows.
    always_comb begin
        ir_ev_s   = ir_map(ir_code);
        btn_ev_s  = btn_map(btn_fall_s);
        ir_evt_s  = 1'b0;
        btn_evt_s = 1'b0;
        if (ir_strobe && ir_ev_s.vld) begin
            ir_evt_s = !((ir_hold_r != {HW{1'b0}}) && (ir_code == ir_last_r));
        end else begin
            ir_evt_s = 1'b0;
        end
        if (btn_ev_s.vld && (btn_hold_r == {HW{1'b0}})) begin
            btn_evt_s = 1'b1;
        end else begin
            btn_evt_s = 1'b0;
        end
    end

    // Holdoff countdowns; an accepted event restarts its source window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_hold_r  <= {HW{1'b0}};
            btn_hold_r <= {HW{1'b0}};
            ir_last_r  <= 8'h00;
        end else begin
            if (ir_evt_s) begin
                ir_hold_r <= HOLD_LD;
                ir_last_r <= ir_code;
            end else if (ir_hold_r != {HW{1'b0}}) begin
                ir_hold_r <= ir_hold_r - HW'(32'd1);
            end
            if (btn_evt_s) begin
                btn_hold_r <= HOLD_LD;
            end else if (btn_hold_r != {HW{1'b0}}) begin
                btn_hold_r <= btn_hold_r - HW'(32'd1);
            end
        end
    end

    // Arbiter: rr pointer only matters, and only moves, when both sources contend.
    always_comb begin
        gnt_ir_s  = 1'b0;
        gnt_btn_s = 1'b0;
        if (!fifo_full_s || pop_s) begin
            if (ir_pend_vld_r && btn_pend_vld_r) begin
                if (rr_r == SRC_IR) begin
                    gnt_ir_s = 1'b1;
                end else begin
                    gnt_btn_s = 1'b1;
                end
            end else if (ir_pend_vld_r) begin
                gnt_ir_s = 1'b1;
            end else if (btn_pend_vld_r) begin
                gnt_btn_s = 1'b1;
            end else begin
                gnt_ir_s = 1'b0;
            end
        end else begin
            gnt_ir_s = 1'b0;
        end
        push_s     = gnt_ir_s | gnt_btn_s;
        push_cmd_s = gnt_ir_s ? ir_pend_r : btn_pend_r;
        ir_drop_s  = ir_evt_s & ir_pend_vld_r & ~gnt_ir_s;
        btn_drop_s = btn_evt_s & btn_pend_vld_r & ~gnt_btn_s;
    end

    // Per-source pending registers; a slot freed by this cycle's grant can refill at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_pend_r      <= CMD_NOP;
            ir_pend_vld_r  <= 1'b0;
            btn_pend_r     <= CMD_NOP;
            btn_pend_vld_r <= 1'b0;
            rr_r           <= SRC_IR;
        end else begin
            if (ir_evt_s && (!ir_pend_vld_r || gnt_ir_s)) begin
                ir_pend_r     <= ir_ev_s.cmd;
                ir_pend_vld_r <= 1'b1;
            end else if (gnt_ir_s) begin
                ir_pend_vld_r <= 1'b0;
            end
            if (btn_evt_s && (!btn_pend_vld_r || gnt_btn_s)) begin
                btn_pend_r     <= btn_ev_s.cmd;
                btn_pend_vld_r <= 1'b1;
            end else if (gnt_btn_s) begin
                btn_pend_vld_r <= 1'b0;
            end
            if (gnt_ir_s && btn_pend_vld_r) begin
                rr_r <= SRC_BTN;
            end else if (gnt_btn_s && ir_pend_vld_r) begin
                rr_r <= SRC_IR;
            end
        end
    end

    irc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (push_cmd_s),
        .pop   (pop_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

`ifdef IRC_EXEC_TIMEOUT_EN
    localparam int unsigned TW        = $clog2(TIMEOUT_CYC + 32'd1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 32'd1);
    logic [TW-1:0] to_cnt_r;

    // Cycles spent in EXEC for the current command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= {TW{1'b0}};
        end else if (state_r != ST_EXEC) begin
            to_cnt_r <= {TW{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_r + TW'(32'd1);
        end
    end
`endif

    // Issue FSM next-state logic.
    always_comb begin
        state_nxt = state_r;
        pop_s     = 1'b0;
        hs_s      = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    state_nxt = ST_ISSUE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    hs_s      = 1'b1;
                    state_nxt = ST_EXEC;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_EXEC: begin
                if (cmd_done) begin
                    state_nxt = ST_IDLE;
                end
`ifdef IRC_EXEC_TIMEOUT_EN
                else if (to_cnt_r == TO_LAST) begin
                    timeout_s = 1'b1;
                    state_nxt = ST_IDLE;
                end
`endif
                else begin
                    state_nxt = ST_EXEC;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Mode ops carry the post-update mode as their argument, fixed at pop time.
    always_comb begin
        mode_calc_s  = mode_r;
        issue_arg_s  = fifo_head_s.arg;
        is_mode_op_s = 1'b0;
        case (fifo_head_s.op)
            OP_MODE_NEXT:  mode_calc_s = (mode_r >= MODE_LAST) ? 3'd0 : mode_r + 3'd1;
            OP_MODE_PREV:  mode_calc_s = (mode_r == 3'd0) ? MODE_LAST : mode_r - 3'd1;
            OP_MODE_RESET: mode_calc_s = 3'd0;
            default:       mode_calc_s = mode_r;
        endcase
        case (fifo_head_s.op)
            OP_MODE_NEXT, OP_MODE_PREV, OP_MODE_RESET: issue_arg_s = {5'b00000, mode_calc_s};
            default:                                   issue_arg_s = fifo_head_s.arg;
        endcase
        case (cmd_op_r)
            OP_MODE_NEXT, OP_MODE_PREV, OP_MODE_RESET: is_mode_op_s = 1'b1;
            default:                                   is_mode_op_s = 1'b0;
        endcase
        drop_inc_s = {1'b0, ir_drop_s} + {1'b0, btn_drop_s} + {1'b0, timeout_s};
        drop_sum_s = {1'b0, drop_cnt_r} + {7'b0000000, drop_inc_s};
    end

    // FSM state and registered command/mode/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cmd_valid_r <= 1'b0;
            cmd_op_r    <= OP_NOP;
            cmd_arg_r   <= 8'h00;
            mode_r      <= 3'd0;
            busy_r      <= 1'b0;
            drop_cnt_r  <= 8'h00;
        end else begin
            state_r <= state_nxt;
            if (pop_s) begin
                cmd_valid_r <= 1'b1;
                cmd_op_r    <= fifo_head_s.op;
                cmd_arg_r   <= issue_arg_s;
            end else if (hs_s) begin
                cmd_valid_r <= 1'b0;
                if (is_mode_op_s) begin
                    mode_r <= cmd_arg_r[2:0];
                end
            end
            busy_r     <= (state_nxt != ST_IDLE) | push_s | ~fifo_empty_s;
            drop_cnt_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
        end
    end

endmodule

// File: tb/tb_ir_cmd_sched.sv
// Directed self-checking bench for ir_cmd_sched: vector table for single IR
// commands plus hand-written holdoff, arbitration, overflow and reset sequences.
module tb_ir_cmd_sched;
    import irc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir_code;
    logic       ir_strobe;
    logic [3:0] btn_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       cmd_done;
    logic [2:0] mode;
    logic       busy;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    logic       done_en = 1'b1;
    logic [3:0] log_op[$];
    logic [7:0] log_arg[$];

    always #5 clk = ~clk;

    ir_cmd_sched #(
        .HOLDOFF_CYC (100),
        .FIFO_DEPTH  (4),
        .MODE_COUNT  (5)
`ifdef IRC_EXEC_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (50)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir_code   (ir_code),
        .ir_strobe (ir_strobe),
        .btn_n     (btn_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_done  (cmd_done),
        .mode      (mode),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        logic [7:0] code;
        logic       has_cmd;
        logic [3:0] op;
        logic [7:0] arg;
        logic [2:0] mode;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ir_send(input logic [7:0] c);
        ir_code   = c;
        ir_strobe = 1'b1;
        tick();
        ir_strobe = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!cmd_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_valid"}, 32'(cmd_valid), 32'd1);
    endtask

    task automatic check_log(input string nm, input int n,
                             input logic [3:0] eop [6], input logic [7:0] earg [6]);
        chk({nm, "_count"}, 32'(log_op.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < log_op.size()) begin
                chk($sformatf("%s_op%0d", nm, i), 32'(log_op[i]), 32'(eop[i]));
                chk($sformatf("%s_arg%0d", nm, i), 32'(log_arg[i]), 32'(earg[i]));
            end
        end
    endtask

    // Datapath model: log each handshake and answer with a done pulse.
    initial begin
        cmd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_valid && cmd_ready) begin
                log_op.push_back(cmd_op);
                log_arg.push_back(cmd_arg);
                @(posedge clk);
                @(negedge clk);
                if (done_en) begin
                    cmd_done = 1'b1;
                    @(negedge clk);
                    cmd_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[13];
        logic [3:0] eo[6];
        logic [7:0] ea[6];
        int lat;

        vecs[0]  = '{8'h12, 1'b1, 4'd1, 8'd0, 3'd0};
        vecs[1]  = '{8'h1A, 1'b1, 4'd2, 8'd1, 3'd1};
        vecs[2]  = '{8'h1A, 1'b1, 4'd2, 8'd2, 3'd2};
        vecs[3]  = '{8'h1A, 1'b1, 4'd2, 8'd3, 3'd3};
        vecs[4]  = '{8'h1A, 1'b1, 4'd2, 8'd4, 3'd4};
        vecs[5]  = '{8'h1A, 1'b1, 4'd2, 8'd0, 3'd0};
        vecs[6]  = '{8'h1E, 1'b1, 4'd3, 8'd4, 3'd4};
        vecs[7]  = '{8'h1E, 1'b1, 4'd3, 8'd3, 3'd3};
        vecs[8]  = '{8'h05, 1'b1, 4'd4, 8'd5, 3'd3};
        vecs[9]  = '{8'h09, 1'b1, 4'd4, 8'd9, 3'd3};
        vecs[10] = '{8'h0A, 1'b0, 4'd0, 8'd0, 3'd3};
        vecs[11] = '{8'h00, 1'b1, 4'd4, 8'd0, 3'd3};
        vecs[12] = '{8'h13, 1'b0, 4'd0, 8'd0, 3'd3};

        rst_n     = 1'b0;
        ir_code   = 8'h00;
        ir_strobe = 1'b0;
        btn_n     = 4'hF;
        cmd_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_op",    32'(cmd_op),    32'd0);
        chk("rst_arg",   32'(cmd_arg),   32'd0);
        chk("rst_mode",  32'(mode),      32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int k = 0; k < 13; k++) begin
            ir_send(vecs[k].code);
            lat = 1;
            while (!cmd_valid && lat < 12) begin
                tick();
                lat++;
            end
            if (vecs[k].has_cmd) begin
                chk($sformatf("v%0d_latency", k), 32'(lat), 32'd3);
                chk($sformatf("v%0d_op", k), 32'(cmd_op), 32'(vecs[k].op));
                chk($sformatf("v%0d_arg", k), 32'(cmd_arg), 32'(vecs[k].arg));
                chk($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
                wait_idle($sformatf("v%0d", k), 20);
            end else begin
                chk($sformatf("v%0d_novalid", k), 32'(cmd_valid), 32'd0);
                chk($sformatf("v%0d_nobusy", k), 32'(busy), 32'd0);
            end
            chk($sformatf("v%0d_mode", k), 32'(mode), 32'(vecs[k].mode));
            repeat (105) tick();
        end

        // Repeated identical IR code inside the holdoff window yields one command.
        log_op.delete(); log_arg.delete();
        ir_send(8'h1A); repeat (19) tick();
        ir_send(8'h1A); repeat (19) tick();
        ir_send(8'h1A); repeat (60) tick();
        eo = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        ea = '{8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        check_log("holdoff", 1, eo, ea);
        chk("holdoff_mode", 32'(mode), 32'd4);
        repeat (110) tick();

        // Different codes back-to-back are both accepted.
        log_op.delete(); log_arg.delete();
        ir_send(8'h1A);
        ir_send(8'h1E);
        repeat (30) tick();
        eo = '{4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
        ea = '{8'd0, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        check_log("b2b", 2, eo, ea);
        chk("b2b_mode", 32'(mode), 32'd4);
        repeat (110) tick();

        // Button 3 resets the display mode.
        log_op.delete(); log_arg.delete();
        btn_n = 4'b0111;
        repeat (20) tick();
        btn_n = 4'hF;
        wait_idle("btn3", 20);
        eo = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        ea = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        check_log("btn3", 1, eo, ea);
        chk("btn3_mode", 32'(mode), 32'd0);
        repeat (110) tick();

        // Simultaneous IR and button events: round-robin order alternates.
        log_op.delete(); log_arg.delete();
        btn_n = 4'b1110;
        tick(); tick();
        ir_send(8'h03);
        repeat (30) tick();
        btn_n = 4'hF;
        repeat (110) tick();
        btn_n = 4'b1110;
        tick(); tick();
        ir_send(8'h04);
        repeat (30) tick();
        btn_n = 4'hF;
        eo = '{4'd4, 4'd1, 4'd1, 4'd4, 4'd0, 4'd0};
        ea = '{8'd3, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0};
        check_log("rr", 4, eo, ea);
        repeat (110) tick();

        // Stalled datapath: issue slot + 4 FIFO + 1 pending hold six, seventh drops.
        log_op.delete(); log_arg.delete();
        cmd_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ir_send(8'(i));
            tick();
        end
        repeat (3) tick();
        chk("ovf_drop",  32'(drop_cnt),  32'd1);
        chk("ovf_valid", 32'(cmd_valid), 32'd1);
        chk("ovf_arg",   32'(cmd_arg),   32'd0);
        chk("ovf_busy",  32'(busy),      32'd1);
        cmd_ready = 1'b1;
        wait_idle("ovf", 100);
        repeat (5) tick();
        eo = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
        ea = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        check_log("ovf", 6, eo, ea);
        chk("ovf_drop_after", 32'(drop_cnt), 32'd1);

        // Asynchronous reset while a command is executing.
        done_en = 1'b0;
        ir_send(8'h1A);
        wait_valid("rexec");
        tick(); tick();
        chk("rexec_busy", 32'(busy), 32'd1);
        chk("rexec_mode", 32'(mode), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(cmd_valid), 32'd0);
        chk("arst_op",    32'(cmd_op),    32'd0);
        chk("arst_arg",   32'(cmd_arg),   32'd0);
        chk("arst_mode",  32'(mode),      32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_drop",  32'(drop_cnt),  32'd0);
        tick();
        rst_n   = 1'b1;
        done_en = 1'b1;
        repeat (5) tick();
        chk("arst_stay_idle", 32'(busy), 32'd0);

`ifdef IRC_EXEC_TIMEOUT_EN
        begin
            int n = 0;
            done_en = 1'b0;
            ir_send(8'h12);
            wait_valid("tmo");
            tick();
            while (busy && n < 200) begin
                tick();
                n++;
            end
            chk("tmo_cycles", 32'(n), 32'd50);
            chk("tmo_drop", 32'(drop_cnt), 32'd1);
            done_en = 1'b1;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
